// File: rtl/tt_adder_pkg.sv
// Shared definitions for the byte-serial adder/subtractor: op encodings,
// FSM state type and the byte-index width helper.
package tt_adder_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_ACC = 2'b10;

  typedef enum logic [1:0] {
    LOAD_A = 2'b00,
    LOAD_B = 2'b01,
    CALC   = 2'b10,
    OUT    = 2'b11
  } state_t;

  // A single-byte operand still needs a 1-bit index register.
  function automatic int idx_width(input int bytes);
    return (bytes > 1) ? $clog2(bytes) : 1;
  endfunction

endpackage

// File: rtl/byte_add_slice.sv
// One byte of the ripple datapath: A + (B ^ invert) + carry_in, plus the
// MSB taps the top needs to form signed overflow on the final byte.
module byte_add_slice (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       invert_b,
  input  logic       carry_in,
  output logic [7:0] sum,
  output logic       carry_out,
  output logic       a_msb,
  output logic       b_msb,
  output logic       sum_msb
);

  logic [7:0] b_eff;

  assign b_eff              = b ^ {8{invert_b}};
  assign {carry_out, sum}   = {1'b0, a} + {1'b0, b_eff} + {8'd0, carry_in};
  assign a_msb              = a[7];
  assign b_msb              = b_eff[7];
  assign sum_msb            = sum[7];

endmodule

// File: rtl/tt_adder_seq.sv
// Byte-serial multi-precision adder/subtractor with accumulate mode.
// Operands stream in LSB byte first, one byte is computed per cycle, result streams out.
module tt_adder_seq
  import tt_adder_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  input  logic [1:0] op,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       out_last,
  output logic       carry_out,
  output logic       overflow
);

  localparam int            BYTES    = WIDTH / 8;
  localparam int            IW       = idx_width(BYTES);
  localparam logic [IW-1:0] LAST_IDX = IW'(BYTES - 1);

  state_t                  state, state_next;
  logic [IW-1:0]           idx, idx_next;
  logic [1:0]              op_reg;
  logic                    carry_reg;
  logic [BYTES-1:0][7:0]   a_reg;
  logic [BYTES-1:0][7:0]   b_reg;
  logic [BYTES-1:0][7:0]   r_reg;

  logic                    load_a_en;
  logic                    load_b_en;
  logic                    acc_start;
  logic                    calc_en;
  logic                    first_byte;
  logic                    is_last;

  logic                    is_sub;
  logic                    slice_cin;
  logic [7:0]              slice_sum;
  logic                    slice_cout;
  logic                    slice_a_msb;
  logic                    slice_b_msb;
  logic                    slice_sum_msb;

  assign is_last    = (idx == LAST_IDX);
  assign first_byte = (state == LOAD_A) && in_valid && (idx == '0);
  assign is_sub     = (op_reg == OP_SUB);
  // Byte 0 seeds the ripple with the subtract carry; later bytes use the registered carry.
  assign slice_cin  = (idx == '0) ? is_sub : carry_reg;

  byte_add_slice u_slice (
    .a         (a_reg[idx]),
    .b         (b_reg[idx]),
    .invert_b  (is_sub),
    .carry_in  (slice_cin),
    .sum       (slice_sum),
    .carry_out (slice_cout),
    .a_msb     (slice_a_msb),
    .b_msb     (slice_b_msb),
    .sum_msb   (slice_sum_msb)
  );

  assign in_ready  = (state == LOAD_A) || (state == LOAD_B);
  assign out_valid = (state == OUT);
  assign out_last  = out_valid && is_last;
  assign out_data  = out_valid ? r_reg[idx] : 8'd0;

  // NOTE: every signal gets a default before the case so no path infers a latch.
  always_comb begin
    state_next = state;
    idx_next   = idx;
    load_a_en  = 1'b0;
    load_b_en  = 1'b0;
    acc_start  = 1'b0;
    calc_en    = 1'b0;
    case (state)
      LOAD_A: begin
        if (in_valid) begin
          if ((idx == '0) && (op == OP_ACC)) begin
            acc_start = 1'b1;
            if (BYTES == 1) begin
              state_next = CALC;
              idx_next   = '0;
            end else begin
              state_next = LOAD_B;
              idx_next   = IW'(1);
            end
          end else begin
            load_a_en = 1'b1;
            if (is_last) begin
              state_next = LOAD_B;
              idx_next   = '0;
            end else begin
              idx_next = idx + 1'b1;
            end
          end
        end
      end
      LOAD_B: begin
        if (in_valid) begin
          load_b_en = 1'b1;
          if (is_last) begin
            state_next = CALC;
            idx_next   = '0;
          end else begin
            idx_next = idx + 1'b1;
          end
        end
      end
      CALC: begin
        calc_en = 1'b1;
        if (is_last) begin
          state_next = OUT;
          idx_next   = '0;
        end else begin
          idx_next = idx + 1'b1;
        end
      end
      OUT: begin
        if (out_ready) begin
          if (is_last) begin
            state_next = LOAD_A;
            idx_next   = '0;
          end else begin
            idx_next = idx + 1'b1;
          end
        end
      end
      default: begin
        state_next = LOAD_A;
        idx_next   = '0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= LOAD_A;
      idx   <= '0;
    end else begin
      state <= state_next;
      idx   <= idx_next;
    end
  end

  // NOTE: the operand/result arrays are reset because ACC reads R right after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_reg    <= OP_ADD;
      carry_reg <= 1'b0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
      a_reg     <= '0;
      b_reg     <= '0;
      r_reg     <= '0;
    end else begin
      if (first_byte) begin
        op_reg <= op;
      end
      if (acc_start) begin
        a_reg    <= r_reg;
        b_reg[0] <= in_data;
      end
      if (load_a_en) begin
        a_reg[idx] <= in_data;
      end
      if (load_b_en) begin
        b_reg[idx] <= in_data;
      end
      if (calc_en) begin
        r_reg[idx] <= slice_sum;
        carry_reg  <= slice_cout;
        if (is_last) begin
          carry_out <= slice_cout;
          overflow  <= (slice_a_msb == slice_b_msb) && (slice_sum_msb != slice_a_msb);
        end
      end
    end
  end

endmodule

// File: doc/tt_adder_seq.md
# tt_adder_seq

Parametrised, byte-serial multi-precision adder/subtractor, the successor to the single-cycle 8-pin adder in our Tiny Tapeout top. Operands of WIDTH bits stream in LSB byte first over an 8-bit valid/ready port. The sum or difference is computed one byte per cycle with a registered carry, and the result streams out the same way. An accumulate mode reuses the previous result as operand A. The Tiny Tapeout top wrapper instantiates it and maps ui_in/uo_out/uio onto the ports.

## Interface
- WIDTH, 16, operand/result width in bits. Must be a multiple of 8 and ≥ 8. BYTES = WIDTH/8.
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  input byte valid.
- in_ready  out  1  block accepts input bytes.
- in_data  in  8  operand byte, LSB byte first.
- op  in  2  operation: 00 ADD, 01 SUB, 10 ACC, 11 treated as ADD. Sampled only on the first accepted byte of a transaction.
- out_valid  out  1  result byte valid.
- out_ready  in  1  downstream accepts the result byte.
- out_data  out  8  result byte, LSB byte first.
- out_last  out  1  marks the MSB result byte.
- carry_out  out  1  final carry. For SUB, 1 means no borrow.
- overflow  out  1  signed (two's-complement) overflow.

## Operation
- A byte transfers on the rising clk edge when valid and ready are both high.
- FSM states: LOAD_A, LOAD_B, CALC, OUT. Byte index register idx counts 0..BYTES-1.
- LOAD_A (in_ready=1):
  - The first accepted byte latches op.
  - If op=ACC: A is taken from the result register, and the byte goes to B[0]. Next state is LOAD_B with idx=1, or CALC if BYTES=1.
  - Otherwise: bytes fill A[idx]. After byte BYTES-1 is accepted, go to LOAD_B with idx=0.
- LOAD_B (in_ready=1): bytes fill B[idx]. After byte BYTES-1 is accepted, go to CALC with idx=0.
- CALC (in_ready=0, out_valid=0): one byte per cycle.
  - Initial carry c = (op==SUB).
  - Per byte: {c, R[idx]} = A[idx] + (B[idx] ^ {8{sub}}) + c.
  - After byte BYTES-1: carry_out = final c; overflow = (A_msb == B'_msb) && (R_msb != A_msb), where B' is the possibly inverted B.
  - Then go to OUT with idx=0.
- OUT (in_ready=0, out_valid=1):
  - out_data = R[idx]; out_last = (idx == BYTES-1).
  - Each accepted byte advances idx. Acceptance of the last byte returns the FSM to LOAD_A.
- out_data is 0 whenever out_valid=0.
- Holding values:
  - carry_out and overflow hold from the end of CALC until the next CALC completes.
  - The result register R holds until the next CALC and is the ACC source.
- in_valid while in_ready=0 is ignored; the data is not stored.
- op changes after the first accepted byte have no effect.

## Timing
- Reset values: state LOAD_A, in_ready=1, out_valid=0, out_data=0, out_last=0, carry_out=0, overflow=0, A=B=R=0, idx=0.
- Load throughput: 1 byte/cycle with in_valid held high. A transaction takes 2·BYTES bytes, or BYTES bytes in ACC mode.
- Latency: last B byte accepted at edge t → CALC occupies edges t+1..t+BYTES → out_valid high after edge t+BYTES.
- Output backpressure: with out_ready low, out_data and out_last stay stable and the FSM stalls indefinitely.
- The first byte of the next transaction can be accepted in the cycle after the last output byte is accepted.
- Reset mid-operation: rst_n low immediately clears all state and outputs. A partial transaction is discarded, and ACC restarts from R=0.

## Structure
- Package tt_adder_pkg holds:
  - op encodings OP_ADD, OP_SUB, OP_ACC;
  - state enum (LOAD_A, LOAD_B, CALC, OUT);
  - a function computing byte-index width from BYTES (minimum 1 bit).
- Sub-module byte_add_slice: combinational 8-bit add with invert-B, carry-in, carry-out and MSB signals for overflow. Instantiated once and reused every CALC cycle.
- All remaining logic (FSM, operand/result byte arrays, idx counter, handshakes) lives in tt_adder_seq.

## Test plan (WIDTH=16)
- ADD: A bytes 34,12 and B bytes 0F,0F → out 43, 21 (out_last on 21), carry_out=0, overflow=0. out_valid rises 2 cycles after the last B byte.
- ADD carry: 0xFFFF + 0x0001 → out 00, 00; carry_out=1, overflow=0.
- SUB overflow: 0x8000 − 0x0001 → out FF, 7F; carry_out=1, overflow=1. Also 0x0001 − 0x0002 → FF, FF; carry_out=0, overflow=0.
- ACC: after reset, ACC with B=0x0005 → 05, 00. A second ACC with B=0x0005 → 0A, 00, with only 2 input bytes accepted each time.
- Backpressure/ignore:
  - Hold out_ready low 3 cycles in OUT → out_data=43 stable and in_ready=0.
  - Pulse in_valid during CALC → no effect on the result.
- Reset mid-LOAD_B: assert rst_n low after A plus 1 B byte → in_ready=1 and out_valid=0 at once. A fresh ADD 0x0102 + 0x0304 → 06, 04. A subsequent ACC with B=0x0001 uses the post-reset R.
